// File: rtl/timer_pkg.sv
// Shared definitions for the reload timer:
//   - default count and prescaler widths
//   - FSM state type (IDLE / LOAD / RUN)
package timer_pkg;

  localparam int unsigned TIMER_WIDTH   = 32;
  localparam int unsigned TIMER_PRESC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the reload timer: emits one tick every presc+1 enabled clocks.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset
//   clear  - synchronous clear of the prescaler count
//   en     - advance the prescaler this cycle
//   presc  - divisor minus one, compared live every cycle
//   tick   - combinational tick, high when enabled and count equals presc
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = TIMER_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] r_cnt;

  assign tick = en && (r_cnt == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      if (tick) r_cnt <= '0;
      else      r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_reload_ctrl.sv
// Down-counting timer with one-shot / auto-reload modes, prescaler,
// registered terminal-count pulse and sticky interrupt flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - load reload and begin counting (restarts when already busy)
//   stop     - return to IDLE holding cnt; beats start and terminal count
//   periodic - 1: auto-reload at terminal count, 0: one-shot
//   reload   - start value of the down-count
//   presc    - one count tick every presc+1 clocks
//   irq_ack  - clears irq
//   cnt      - current count value
//   busy     - high in LOAD and RUN
//   tc       - one-cycle terminal-count pulse
//   irq      - sticky interrupt flag
//
// state | meaning
// IDLE  | not counting, cnt holds its last value
// LOAD  | one cycle: cnt <= reload, prescaler cleared
// RUN   | counting down on prescaler ticks
module timer_reload_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH   = TIMER_WIDTH,
  parameter int PRESC_W = TIMER_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               periodic,
  input  logic [WIDTH-1:0]   reload,
  input  logic [PRESC_W-1:0] presc,
  input  logic               irq_ack,
  output logic [WIDTH-1:0]   cnt,
  output logic               busy,
  output logic               tc,
  output logic               irq
);

  timer_state_e     r_state;
  timer_state_e     w_next_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic             r_tc;
  logic             r_irq;
  logic             w_tick;
  logic             w_tc_event;
  logic             w_presc_clear;
  logic             w_presc_en;

  // Prescaler is frozen while stop is asserted so a stopped cycle never
  // consumes a tick.
  assign w_presc_clear = (r_state == LOAD);
  assign w_presc_en    = (r_state == RUN) && !stop;

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clear (w_presc_clear),
    .en    (w_presc_en),
    .presc (presc),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tc    <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_tc    <= w_tc_event;
      if (w_tc_event)   r_irq <= 1'b1;
      else if (irq_ack) r_irq <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_tc_event   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!stop && start) w_next_state = LOAD;
      end
      LOAD: begin
        if (stop) begin
          w_next_state = IDLE;
        end else begin
          w_cnt_next   = reload;
          w_next_state = start ? LOAD : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_next_state = IDLE;
        end else begin
          if (w_tick) begin
            if (r_cnt != '0) begin
              w_cnt_next = r_cnt - WIDTH'(1);
            end else begin
              w_tc_event = 1'b1;
              if (periodic) w_cnt_next   = reload;
              else          w_next_state = IDLE;
            end
          end
          // A restart still lets a coincident terminal count report first.
          if (start) w_next_state = LOAD;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign cnt  = r_cnt;
  assign busy = (r_state != IDLE);
  assign tc   = r_tc;
  assign irq  = r_irq;

endmodule
